// File: rtl/multiplicador_param_pkg.sv
// Shared types and defaults for the parametrised shift-add multiplier.
package mult_pkg;

    localparam int MULT_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/multiplicador_param_if.sv
// Start/busy handshake and operand/result bus of the multiplier.
// Carries signed_mode only when MULT_SIGNED_EN is defined.
interface multiplicador_param_if
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEF
);

    logic                 start;
    logic [WIDTH-1:0]     P;
    logic [WIDTH-1:0]     Q;
`ifdef MULT_SIGNED_EN
    logic                 signed_mode;
`endif
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   M;

`ifdef MULT_SIGNED_EN
    modport master (output start, P, Q, signed_mode, input busy, done, M);
    modport slave  (input start, P, Q, signed_mode, output busy, done, M);
`else
    modport master (output start, P, Q, input busy, done, M);
    modport slave  (input start, P, Q, output busy, done, M);
`endif

endinterface

// File: rtl/multiplicador_param_fsm.sv
// Control for the multiplier: state register, iteration counter and the
// busy/done decode plus datapath strobes (load, calc, last iteration).
module multiplicador_fsm
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic load,
    output logic calc,
    output logic last,
    output logic busy,
    output logic done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mult_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        calc       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE, DONE: begin
                // DONE accepts a new request exactly like IDLE
                if (start) begin
                    load       = 1'b1;
                    cnt_next   = '0;
                    state_next = CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                calc     = 1'b1;
                cnt_next = cnt + 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last       = 1'b1;
                    cnt_next   = '0;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule

// File: rtl/multiplicador_param.sv
// Sequential shift-add multiplier, one iteration per cycle, WIDTH cycles.
// Define MULT_SIGNED_EN to add two's-complement operation via signed_mode.
module multiplicador_param
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    multiplicador_param_if.slave bus
);

    logic               load, calc, last;
    logic [WIDTH-1:0]   mag_p, mag_q;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] mcand, acc, sum, result, m_q;

    multiplicador_fsm #(.WIDTH(WIDTH)) u_fsm (
        .clk   (clk),
        .rst   (rst),
        .start (bus.start),
        .load  (load),
        .calc  (calc),
        .last  (last),
        .busy  (bus.busy),
        .done  (bus.done)
    );

`ifdef MULT_SIGNED_EN
    logic neg, neg_in;

    // Magnitudes are WIDTH-bit unsigned, so the most negative value is exact.
    always_comb begin
        mag_p  = (bus.signed_mode && bus.P[WIDTH-1]) ? (~bus.P + 1'b1) : bus.P;
        mag_q  = (bus.signed_mode && bus.Q[WIDTH-1]) ? (~bus.Q + 1'b1) : bus.Q;
        neg_in = bus.signed_mode && (bus.P[WIDTH-1] ^ bus.Q[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst)       neg <= 1'b0;
        else if (load) neg <= neg_in;
    end
`else
    always_comb begin
        mag_p = bus.P;
        mag_q = bus.Q;
    end
`endif

    always_comb begin
        sum = acc + (mplier[0] ? mcand : '0);
`ifdef MULT_SIGNED_EN
        result = neg ? (~sum + 1'b1) : sum;
`else
        result = sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            m_q    <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_p};
            mplier <= mag_q;
        end else if (calc) begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (last) m_q <= result;
        end
    end

    assign bus.M = m_q;

endmodule

// File: doc/multiplicador_param.md
# multiplicador_param

Parametrised sequential shift-add multiplier. Next generation of the 8-bit TOP_multiplicador: operand width set by parameter, synchronous reset, a one-cycle `done` pulse, and optional signed (two's-complement) operation. The block is a datapath peripheral driven by a start/busy handshake from the top-level control.

## Interface
- `WIDTH`, default 8: operand width in bits. Minimum is 2.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: request a multiply. Sampled on the rising edge.
- `P`  in  WIDTH: multiplicand. Captured only at an accepted start.
- `Q`  in  WIDTH: multiplier. Captured only at an accepted start.
- `signed_mode`  in  1: 1 = two's-complement operands. Present only with `MULT_SIGNED_EN` and captured with P/Q.
- `busy`  out  1: high while a computation is in progress.
- `done`  out  1: single-cycle pulse when M is updated.
- `M`  out  2*WIDTH: product register. Holds its value until the next result.

## Operation
- Reset values: `busy`=0, `done`=0, `M`=0, state IDLE, iteration counter 0.
- States:
  - IDLE: if `start`=1, capture P/Q (and mode), clear the accumulator and counter, then go to CALC. Otherwise stay in IDLE.
  - CALC: perform one iteration per cycle.
    - Add the shifted multiplicand to the accumulator if the current multiplier LSB is 1.
    - Shift the multiplier right and the multiplicand left, then increment the counter.
    - After the WIDTH-th iteration, write the accumulator to M and go to DONE.
  - DONE: `done`=1 for exactly one cycle.
    - If `start`=1, the new request is accepted exactly as in IDLE and the state goes to CALC.
    - Otherwise go to IDLE.
- While in CALC, `start` is ignored and P/Q changes have no effect.
- There is no early termination: zero operands still take WIDTH iterations.
- Width rules:
  - The accumulator is 2*WIDTH bits.
  - The unsigned product of two all-ones operands, (2^WIDTH−1)^2, fits without overflow.
  - The counter is $clog2(WIDTH+1) bits.
- Signed mode:
  - Operands are converted to magnitude and sign at capture. The magnitude is WIDTH-bit unsigned, so −2^(WIDTH−1) is exact.
  - The magnitudes are multiplied unsigned.
  - The result is two's-complement negated when writing M if the operand signs differ.
- Reset asserted in any state, including mid-CALC, aborts the operation and restores all reset values on that edge. M is cleared.

## Timing
- Edge 0 samples `start`=1 in IDLE or DONE. `busy` is 1 from edge 0.
- Edges 1..WIDTH perform the iterations.
- At edge WIDTH, M takes the result, `busy` drops to 0 and `done` goes to 1.
- At edge WIDTH+1, `done` drops to 0.
- Latency from accepted start to `done` is WIDTH cycles. Throughput is one multiply per WIDTH+1 cycles; back-to-back starts are accepted in DONE.
- `busy` and `done` are never high together.
- M is stable except at the edge that asserts `done` and at reset.

## Configuration
- `MULT_SIGNED_EN` defined:
  - The `signed_mode` port exists.
  - The sign/magnitude pre-processing and the result negation logic are instantiated.
- `MULT_SIGNED_EN` not defined:
  - No `signed_mode` port exists.
  - Operation is unsigned only.
  - No negation logic is built.

## Structure
- Package `mult_pkg` holds:
  - typedef `mult_state_t` (IDLE, CALC, DONE), with binary encoding;
  - localparam default `MULT_WIDTH_DEF` = 8.
- Sub-module `multiplicador_fsm` contains the state register, iteration counter, and the `busy`/`done` decode. It takes WIDTH as a parameter.
- Datapath registers (accumulator, shifting operands, sign flag) live in the top module.

## Test plan
- WIDTH=8, P=2, Q=3, start pulsed for 1 cycle -> `busy` is high for 8 cycles, then `done` pulses once with M=16'd6, and M holds 6 afterwards.
- WIDTH=8 operand sweep:
  - 5×63 -> M=315;
  - 0×255 -> M=0;
  - 1×255 -> M=255;
  - 255×0 -> M=0;
  - 255×1 -> M=255;
  - 255×255 -> M=65025 (16'hFE01).
- Start re-asserted and P/Q changed mid-CALC (P=2, Q=3, then P=7 at cycle 3) -> ignored, result is still M=6. A start held in the DONE cycle -> accepted, and `busy` rises on the next edge.
- With `MULT_SIGNED_EN`, signed_mode=1, WIDTH=8:
  - −1×−1 -> M=16'h0001;
  - −128×127 -> M=16'hC080;
  - −128×−128 -> M=16'h4000;
  - 3×−2 -> M=16'hFFFA.
- With signed_mode=0 and P=8'hFF, Q=8'hFF -> M=16'hFE01.
- `rst` pulsed at iteration 4 of 255×255 -> on that edge `busy`=0, `done`=0, M=0. No `done` pulse follows. The next start of 2×3 completes normally with M=6.
- WIDTH=16, 65535×65535 -> `done` arrives 16 cycles after the accepted start, with M=32'hFFFE0001.
